// File: rtl/alu_op_sched.sv
// Shares one ALU between two requesters. Arbitration is round-robin, and one operation is outstanding at a time.
// Define ALU_STICKY_DES_EN to enable the sticky overflow flag; otherwise sticky_des stays 0.
module alu_op_sched #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned OP_W    = 4,
  parameter int unsigned ALU_LAT = 1,
  parameter int unsigned NUM_OPS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OP_W-1:0]  req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OP_W-1:0]  req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OP_W-1:0]  alu_op,
  output logic             alu_start,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_neg,
  input  logic             alu_cero,
  input  logic             alu_carry,
  input  logic             alu_des,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_neg,
  output logic             rsp_cero,
  output logic             rsp_carry,
  output logic             rsp_des,
  output logic             rsp_err,
  output logic             busy,
  input  logic             clr_sticky,
  output logic             sticky_des
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e           state;
  logic             last_grant;
  logic [2:0]       cnt;
  logic             gnt_any, gnt_id, accept, op_legal, cap_now;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [OP_W-1:0]  sel_op;

  always_comb begin
    gnt_any    = req0_valid | req1_valid;
    // On a tie, the requester that did not win last time gets the grant.
    gnt_id     = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    accept     = (state == StIdle) && gnt_any;
    req0_ready = reset && accept && !gnt_id;
    req1_ready = reset && accept && gnt_id;
    sel_a      = gnt_id ? req1_a : req0_a;
    sel_b      = gnt_id ? req1_b : req0_b;
    sel_op     = gnt_id ? req1_op : req0_op;
    op_legal   = 32'(sel_op) < NUM_OPS;
    cap_now    = (state == StIssue && ALU_LAT == 0) || (state == StWait && cnt == 3'd1);
  end

  assign busy = (state != StIdle);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= StIdle;
      last_grant <= 1'b1;
      cnt        <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      alu_start  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_neg    <= 1'b0;
      rsp_cero   <= 1'b0;
      rsp_carry  <= 1'b0;
      rsp_des    <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      alu_start <= 1'b0;
      if (cap_now) begin
        rsp_result <= alu_result;
        rsp_neg    <= alu_neg;
        rsp_cero   <= alu_cero;
        rsp_carry  <= alu_carry;
        rsp_des    <= alu_des;
        rsp_err    <= 1'b0;
      end
      unique case (state)
        StIdle: begin
          if (accept) begin
            alu_a      <= sel_a;
            alu_b      <= sel_b;
            alu_op     <= sel_op;
            rsp_id     <= gnt_id;
            last_grant <= gnt_id;
            if (op_legal) begin
              state     <= StIssue;
              alu_start <= 1'b1;
            end else begin
              // Illegal opcode: answer immediately without touching the ALU.
              state      <= StResp;
              rsp_valid  <= 1'b1;
              rsp_err    <= 1'b1;
              rsp_result <= '0;
              rsp_neg    <= 1'b0;
              rsp_cero   <= 1'b0;
              rsp_carry  <= 1'b0;
              rsp_des    <= 1'b0;
            end
          end
        end
        StIssue: begin
          cnt       <= 3'(ALU_LAT);
          state     <= (ALU_LAT == 0) ? StResp : StWait;
          rsp_valid <= (ALU_LAT == 0);
        end
        StWait: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            state     <= StResp;
            rsp_valid <= 1'b1;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            state     <= StIdle;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

`ifdef ALU_STICKY_DES_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sticky_des <= 1'b0;
    end else if (cap_now && alu_des) begin
      sticky_des <= 1'b1;
    end else if (clr_sticky) begin
      sticky_des <= 1'b0;
    end
  end
`else
  logic unused_clr_sticky;
  assign unused_clr_sticky = clr_sticky;
  assign sticky_des        = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sched.sv
// Bench for alu_op_sched. It runs directed scenarios and then random traffic.
// All traffic is checked against a transaction-level model of the scheduler.
module tb_alu_op_sched;
  localparam int W    = 4;
  localparam int OW   = 4;
  localparam int LAT  = 1;
  localparam int NOPS = 10;

  logic          clk, reset;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic [OW-1:0] req0_op, req1_op;
  logic [W-1:0]  alu_a, alu_b, alu_result, rsp_result;
  logic [OW-1:0] alu_op;
  logic          alu_start, alu_neg, alu_cero, alu_carry, alu_des;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_neg, rsp_cero, rsp_carry, rsp_des, rsp_err;
  logic          busy, clr_sticky, sticky_des;

  alu_op_sched #(.WIDTH(W), .OP_W(OW), .ALU_LAT(LAT), .NUM_OPS(NOPS)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
    .alu_result(alu_result), .alu_neg(alu_neg), .alu_cero(alu_cero), .alu_carry(alu_carry),
    .alu_des(alu_des),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_neg(rsp_neg), .rsp_cero(rsp_cero), .rsp_carry(rsp_carry), .rsp_des(rsp_des),
    .rsp_err(rsp_err), .busy(busy), .clr_sticky(clr_sticky), .sticky_des(sticky_des)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference ALU: returns {des, carry, cero, neg, result}.
  function automatic logic [7:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [3:0] op);
    logic [4:0] s;
    logic des;
    des = 1'b0;
    case (op)
      4'd0: begin s = {1'b0, a} + {1'b0, b}; des = (a[3] == b[3]) && (s[3] != a[3]); end
      4'd1: begin s = {1'b0, a} - {1'b0, b}; des = (a[3] != b[3]) && (s[3] != a[3]); end
      4'd2: s = {1'b0, a & b};
      4'd3: s = {1'b0, a | b};
      4'd4: s = {1'b0, a ^ b};
      4'd5: s = {1'b0, ~a};
      4'd6: s = {a, 1'b0};
      4'd7: s = {a[0], 1'b0, a[3:1]};
      4'd8: begin s = {1'b0, a} + 5'd1; des = (a == 4'h7); end
      default: begin s = {1'b0, a} - 5'd1; des = (a == 4'h8); end
    endcase
    return {des, s[4], s[3:0] == 4'h0, s[3], s[3:0]};
  endfunction

  // Transaction model state
  int         cyc = 0;
  bit         m_active, m_err, m_id, last_g, m_sticky;
  int         m_start_at, m_resp_at;
  logic [3:0] m_a, m_b, m_op;
  logic [7:0] m_fn;
  bit         grants[$];

  task automatic model_reset();
    m_active = 0; m_err = 0; m_id = 0; last_g = 1; m_sticky = 0;
    m_a = '0; m_b = '0; m_op = '0; m_fn = '0;
  endtask

  task automatic step(input bit v0, input logic [3:0] a0, input logic [3:0] b0,
                      input logic [3:0] op0, input bit v1, input logic [3:0] a1,
                      input logic [3:0] b1, input logic [3:0] op1, input bit rr, input bit clr);
    bit exp_rv, gv, gid;
    @(negedge clk);
    cyc++;
    exp_rv = m_active && (cyc >= m_resp_at);
    check_eq("rsp_valid", rsp_valid, exp_rv);
    check_eq("alu_start", alu_start, m_active && !m_err && cyc == m_start_at);
    check_eq("busy", busy, m_active);
    check_eq("alu_operands", {alu_a, alu_b, alu_op}, {m_a, m_b, m_op});
    check_eq("sticky_des", sticky_des, m_sticky);
    if (exp_rv)
      check_eq("rsp_fields",
               {rsp_id, rsp_err, rsp_des, rsp_carry, rsp_cero, rsp_neg, rsp_result},
               m_err ? {m_id, 1'b1, 8'h00} : {m_id, 1'b0, m_fn});
    // ALU outputs are valid only LAT cycles after issue; junk otherwise.
    if (m_active && !m_err && cyc == m_start_at + LAT)
      {alu_des, alu_carry, alu_cero, alu_neg, alu_result} = m_fn;
    else
      {alu_des, alu_carry, alu_cero, alu_neg, alu_result} = 8'($urandom);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
    rsp_ready = rr; clr_sticky = clr;
    #1;
    gv  = v0 | v1;
    gid = (v0 && v1) ? !last_g : v1;
    check_eq("ready", {req1_ready, req0_ready},
             {!m_active && gv && gid, !m_active && gv && !gid});
`ifdef ALU_STICKY_DES_EN
    if (m_active && !m_err && cyc + 1 == m_resp_at && m_fn[7]) m_sticky = 1;
    else if (clr) m_sticky = 0;
`endif
    if (m_active) begin
      if (exp_rv && rr) m_active = 0;
    end else if (gv) begin
      m_active = 1; m_id = gid; last_g = gid;
      m_a  = gid ? a1 : a0;
      m_b  = gid ? b1 : b0;
      m_op = gid ? op1 : op0;
      m_err = (m_op >= NOPS);
      m_fn = alu_fn(m_a, m_b, m_op);
      m_start_at = cyc + 1;
      m_resp_at  = cyc + (m_err ? 1 : LAT + 2);
      grants.push_back(gid);
    end
  endtask

  task automatic idle(input int n, input bit rr);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, rr, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq(tag, {req0_ready, req1_ready, alu_start, rsp_valid, busy, rsp_err, rsp_id,
                   rsp_neg, rsp_cero, rsp_carry, rsp_des, sticky_des},
             32'h0);
    check_eq({tag, "_data"}, {alu_a, alu_b, alu_op, rsp_result}, 32'h0);
  endtask

  initial begin
    reset = 0; req0_valid = 1; req1_valid = 1; rsp_ready = 0; clr_sticky = 0;
    req0_a = 0; req0_b = 0; req0_op = 0; req1_a = 0; req1_b = 0; req1_op = 0;
    {alu_des, alu_carry, alu_cero, alu_neg, alu_result} = '0;
    model_reset();
    #1;
    check_all_zero("reset_outputs");
    @(negedge clk);
    @(negedge clk);
    req0_valid = 0; req1_valid = 0; reset = 1;

    // Both requesters always valid: grants must alternate starting with 0.
    grants.delete();
    for (int i = 0; i < 18; i++) step(1, 4'h3, 4'h5, 4'd2, 1, 4'hC, 4'hA, 4'd3, 1, 0);
    check_eq("grant_count", grants.size() >= 4, 1);
    for (int i = 0; i < 4 && i < grants.size(); i++) check_eq("grant_order", grants[i], i % 2);
    idle(4, 1);

    // ADD 7+9: result 0 with carry, rsp_valid three cycles after accept.
    step(1, 4'd7, 4'd9, 4'd0, 0, 0, 0, 0, 0, 0);
    idle(3, 0);
    check_eq("t1_valid", rsp_valid, 1);
    check_eq("t1_resp", {rsp_id, rsp_result, rsp_neg, rsp_cero, rsp_carry}, {1'b0, 4'h0, 3'b011});
    idle(2, 1);

    // Illegal opcode on requester 1.
    step(0, 0, 0, 0, 1, 4'h5, 4'h6, 4'd12, 0, 0);
    idle(1, 0);
    check_eq("t3_resp", {rsp_valid, rsp_err, rsp_id, rsp_result}, {3'b111, 4'h0});
    idle(2, 1);

    // Response back-pressure with both requesters pending.
    step(0, 0, 0, 0, 1, 4'h2, 4'h9, 4'd1, 0, 0);
    for (int i = 0; i < 7; i++) step(1, 4'h1, 4'h1, 4'd0, 1, 4'h2, 4'h2, 4'd4, 0, 0);
    idle(3, 1);

    // Overflow result followed by a clear at the capture edge of a second overflow.
    step(1, 4'd7, 4'd1, 4'd0, 0, 0, 0, 0, 1, 0);
    idle(4, 1);
    step(1, 4'd1, 4'd2, 4'd0, 0, 0, 0, 0, 1, 0);
    idle(4, 1);
    step(1, 4'd5, 4'd5, 4'd0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(3, 1);

    // Reset in the WAIT state drops the operation.
    step(1, 4'd3, 4'd4, 4'd0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    cyc++;
    reset = 0; req0_valid = 1; req1_valid = 1;
    #1;
    check_all_zero("reset_mid_op");
    model_reset();
    @(negedge clk);
    cyc++;
    req0_valid = 0; req1_valid = 0; reset = 1;
    step(1, 4'd2, 4'd2, 4'd0, 0, 0, 0, 0, 1, 0);
    idle(4, 1);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 2) == 0, 4'($urandom), 4'($urandom), 4'($urandom),
           $urandom_range(0, 2) == 0, 4'($urandom), 4'($urandom), 4'($urandom),
           $urandom_range(0, 9) < 7, $urandom_range(0, 4) == 0);
    idle(8, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
